// File: rtl/color_lut_bank_ctrl_if.sv
`timescale 1ns/1ps
// Configuration-side bus of the double-buffered color LUT controller:
// shadow-bank write handshake, commit/init strobes and busy status.
interface color_lut_bank_ctrl_if #(
  parameter int ADDR_W     = 8,
  parameter int DATA_WIDTH = 12
) ();
  logic                  cfg_wr_valid;
  logic                  cfg_wr_ready;
  logic [ADDR_W-1:0]     cfg_wr_addr;
  logic [DATA_WIDTH-1:0] cfg_wr_data;
  logic                  cfg_commit;
  logic                  cfg_init;
  logic                  cfg_busy;

  modport master (
    output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_commit, cfg_init,
    input  cfg_wr_ready, cfg_busy
  );

  modport slave (
    input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_commit, cfg_init,
    output cfg_wr_ready, cfg_busy
  );
endinterface

// File: rtl/color_lut_bank_ctrl.sv
`timescale 1ns/1ps
// Double-buffered gamma/tone LUT: the datapath reads the active bank, config writes
// the shadow bank, and a commit swaps them at the next vsync rising edge.
module color_lut_bank_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int LUT_DEPTH  = 256,
  parameter int ADDR_W     = $clog2(LUT_DEPTH)
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  color_lut_bank_ctrl_if.slave  cfg,
  input  logic                  pixel_vsync,
  input  logic [ADDR_W-1:0]     lut_rd_addr,
  output logic [DATA_WIDTH-1:0] lut_rd_data,
  output logic                  active_bank,
  output logic                  swap_pulse
);
  localparam int PTR_W    = ADDR_W + 1;
  localparam int RAMP_SHL = DATA_WIDTH - ADDR_W;
  localparam int RAMP_SHR = 2 * ADDR_W - DATA_WIDTH;
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LUT_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PEND = 2'd2,
    ST_COPY = 2'd3
  } state_t;

  // Identity ramp: the index is left-justified and its top bits replicated into the LSBs.
  function automatic logic [DATA_WIDTH-1:0] ramp_entry(input logic [ADDR_W-1:0] idx);
    logic [DATA_WIDTH-1:0] wide_v;
    wide_v = DATA_WIDTH'(idx);
    return (wide_v << RAMP_SHL) | (wide_v >> RAMP_SHR);
  endfunction

  state_t                state_r;
  state_t                state_next_s;
  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      ptr_next_s;
  logic                  init_both_r;
  logic                  init_both_next_s;
  logic                  active_bank_r;
  logic                  active_bank_next_s;
  logic                  swap_pulse_r;
  logic                  swap_pulse_next_s;
  logic                  vsync_d_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  wr_ready_r;
  logic                  busy_r;

  logic [DATA_WIDTH-1:0] bank0_r [LUT_DEPTH];
  logic [DATA_WIDTH-1:0] bank1_r [LUT_DEPTH];

  logic                  vs_rise_s;
  logic                  wr_fire_s;
  logic                  ptr_last_s;
  logic [ADDR_W-1:0]     ptr_addr_s;
  logic                  both_we_s;
  logic                  shadow_we_s;
  logic                  bank0_we_s;
  logic                  bank1_we_s;
  logic [ADDR_W-1:0]     wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [DATA_WIDTH-1:0] copy_src_s;
  logic [DATA_WIDTH-1:0] rd_mux_s;

  assign vs_rise_s  = pixel_vsync & ~vsync_d_r;
  assign wr_fire_s  = cfg.cfg_wr_valid & wr_ready_r;
  assign ptr_addr_s = ptr_r[ADDR_W-1:0];
  assign ptr_last_s = (ptr_r == PTR_LAST);
  assign copy_src_s = active_bank_r ? bank1_r[ptr_addr_s] : bank0_r[ptr_addr_s];
  assign rd_mux_s   = active_bank_r ? bank1_r[lut_rd_addr] : bank0_r[lut_rd_addr];

  // The shadow bank is always the one not being read.
  assign bank0_we_s = both_we_s | (shadow_we_s & active_bank_r);
  assign bank1_we_s = both_we_s | (shadow_we_s & ~active_bank_r);

  // Next-state, pointer sweep and bank write-port selection.
  always_comb begin
    state_next_s       = state_r;
    ptr_next_s         = ptr_r;
    init_both_next_s   = init_both_r;
    active_bank_next_s = active_bank_r;
    swap_pulse_next_s  = 1'b0;
    both_we_s          = 1'b0;
    shadow_we_s        = 1'b0;
    wr_addr_s          = ptr_addr_s;
    wr_data_s          = ramp_entry(ptr_addr_s);
    case (state_r)
      ST_INIT: begin
        if (init_both_r) begin
          both_we_s = 1'b1;
        end else begin
          shadow_we_s = 1'b1;
        end
        if (ptr_last_s) begin
          state_next_s = ST_IDLE;
          ptr_next_s   = PTR_ZERO;
        end else begin
          ptr_next_s = ptr_r + PTR_ONE;
        end
      end
      ST_IDLE: begin
        wr_addr_s = cfg.cfg_wr_addr;
        wr_data_s = cfg.cfg_wr_data;
        if (wr_fire_s) begin
          shadow_we_s = 1'b1;
        end else begin
          shadow_we_s = 1'b0;
        end
        // Commit outranks init; a same-cycle write still lands before the swap.
        if (cfg.cfg_commit) begin
          state_next_s = ST_PEND;
        end else if (cfg.cfg_init) begin
          state_next_s     = ST_INIT;
          init_both_next_s = 1'b0;
          ptr_next_s       = PTR_ZERO;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (vs_rise_s) begin
          state_next_s       = ST_COPY;
          active_bank_next_s = ~active_bank_r;
          swap_pulse_next_s  = 1'b1;
          ptr_next_s         = PTR_ZERO;
        end else begin
          state_next_s = ST_PEND;
        end
      end
      ST_COPY: begin
        shadow_we_s = 1'b1;
        wr_data_s   = copy_src_s;
        if (ptr_last_s) begin
          state_next_s = ST_IDLE;
          ptr_next_s   = PTR_ZERO;
        end else begin
          ptr_next_s = ptr_r + PTR_ONE;
        end
      end
      default: begin
        state_next_s     = ST_INIT;
        init_both_next_s = 1'b1;
        ptr_next_s       = PTR_ZERO;
      end
    endcase
  end

  // Control state, registered outputs and the datapath read register.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_r       <= ST_INIT;
      ptr_r         <= PTR_ZERO;
      init_both_r   <= 1'b1;
      active_bank_r <= 1'b0;
      swap_pulse_r  <= 1'b0;
      vsync_d_r     <= 1'b0;
      rd_data_r     <= {DATA_WIDTH{1'b0}};
      wr_ready_r    <= 1'b0;
      busy_r        <= 1'b1;
    end else begin
      state_r       <= state_next_s;
      ptr_r         <= ptr_next_s;
      init_both_r   <= init_both_next_s;
      active_bank_r <= active_bank_next_s;
      swap_pulse_r  <= swap_pulse_next_s;
      vsync_d_r     <= pixel_vsync;
      rd_data_r     <= rd_mux_s;
      wr_ready_r    <= (state_next_s == ST_IDLE);
      busy_r        <= (state_next_s != ST_IDLE);
    end
  end

  // LUT flop arrays; contents need no reset because INIT always rewrites them.
  always_ff @(posedge pixel_clk) begin
    if (!rst && bank0_we_s) begin
      bank0_r[wr_addr_s] <= wr_data_s;
    end
    if (!rst && bank1_we_s) begin
      bank1_r[wr_addr_s] <= wr_data_s;
    end
  end

  assign lut_rd_data      = rd_data_r;
  assign active_bank      = active_bank_r;
  assign swap_pulse       = swap_pulse_r;
  assign cfg.cfg_wr_ready = wr_ready_r;
  assign cfg.cfg_busy     = busy_r;

endmodule
